// File: rtl/oscillator_phase_gen_pkg.sv
// Shared configuration and oscillator types for the per-voice phase generator.
// CONFIG holds global widths; OSCILLATOR holds the half-cycle flag and phase-gen FSM types.
package CONFIG;

  localparam int LONG_PERCENT_WIDTH = 8;
  localparam int OSC_FRAC_WIDTH     = 8;

  typedef logic [LONG_PERCENT_WIDTH-1:0] long_percent_t;

endpackage

package OSCILLATOR;

  typedef enum logic {
    FRONT = 1'b0,
    BACK  = 1'b1
  } oscillator_state_t;

  typedef enum logic [1:0] {
    PG_IDLE  = 2'd0,
    PG_FRONT = 2'd1,
    PG_BACK  = 2'd2
  } phase_gen_fsm_t;

  // IDLE presents as FRONT so shapers see a quiet rising-half start value.
  function automatic oscillator_state_t fsm_to_osc_state(input phase_gen_fsm_t fsm);
    return (fsm == PG_BACK) ? BACK : FRONT;
  endfunction

endpackage

// File: rtl/oscillator_phase_gen_accumulator.sv
// Fixed-point phase accumulator: synchronous clear, add-enable, and a combinational
// carry-out of the pending addition. Only the MSB phase slice leaves the block.
module phase_accumulator #(
  parameter int PHASE_WIDTH = 8,
  parameter int FRAC_WIDTH  = 8,
  localparam int ACC_WIDTH  = PHASE_WIDTH + FRAC_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clear_i,
  input  logic                   add_en_i,
  input  logic [ACC_WIDTH-1:0]   inc_i,
  output logic [PHASE_WIDTH-1:0] phase_o,
  output logic                   carry_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   sum;

  assign sum     = {1'b0, acc_q} + {1'b0, inc_i};
  assign carry_o = sum[ACC_WIDTH];
  assign phase_o = acc_q[ACC_WIDTH-1 -: PHASE_WIDTH];

  // Residual fraction is kept across a wrap so the period does not drift.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_en_i) begin
      acc_d = sum[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/oscillator_phase_gen.sv
// Per-voice phase source: gates the accumulator on note events and flips the
// FRONT/BACK half-cycle flag on each wrap. Tuning words change only at period starts.
//
//   state    | meaning
//   PG_IDLE  | voice stopped, accumulator held at zero
//   PG_FRONT | rising half of the waveform period
//   PG_BACK  | falling half of the waveform period
module oscillator_phase_gen
  import CONFIG::*;
  import OSCILLATOR::*;
#(
  parameter int PHASE_WIDTH = LONG_PERCENT_WIDTH,
  parameter int FRAC_WIDTH  = OSC_FRAC_WIDTH,
  localparam int ACC_WIDTH  = PHASE_WIDTH + FRAC_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   sample_tick_i,
  input  logic                   note_on_i,
  input  logic                   note_off_i,
  input  logic [ACC_WIDTH-1:0]   increment_i,
  output oscillator_state_t      state_o,
  output logic [PHASE_WIDTH-1:0] phase_o,
  output logic                   active_o,
  output logic                   sample_valid_o,
  output logic                   cycle_start_o
);

  phase_gen_fsm_t       fsm_q, fsm_d;
  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic                 active_q, active_d;
  logic                 valid_q, valid_d;
  logic                 cstart_q, cstart_d;
  logic                 acc_clear;
  logic                 acc_add;
  logic                 acc_carry;

  phase_accumulator #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .FRAC_WIDTH  (FRAC_WIDTH)
  ) u_acc (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (acc_clear),
    .add_en_i (acc_add),
    .inc_i    (inc_q),
    .phase_o  (phase_o),
    .carry_o  (acc_carry)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q    <= PG_IDLE;
      inc_q    <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      cstart_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      inc_q    <= inc_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      cstart_q <= cstart_d;
    end
  end

  // note_on wins over note_off, which wins over sample_tick.
  always_comb begin
    fsm_d     = fsm_q;
    inc_d     = inc_q;
    active_d  = active_q;
    valid_d   = 1'b0;
    cstart_d  = 1'b0;
    acc_clear = 1'b0;
    acc_add   = 1'b0;

    if (note_on_i) begin
      acc_clear = 1'b1;
      inc_d     = increment_i;
      fsm_d     = PG_FRONT;
      active_d  = 1'b1;
    end else if (note_off_i && (fsm_q != PG_IDLE)) begin
      acc_clear = 1'b1;
      fsm_d     = PG_IDLE;
      active_d  = 1'b0;
    end else if (sample_tick_i && (fsm_q != PG_IDLE)) begin
      acc_add = 1'b1;
      valid_d = 1'b1;
      if (acc_carry) begin
        unique case (fsm_q)
          PG_FRONT: fsm_d = PG_BACK;
          PG_BACK: begin
            fsm_d    = PG_FRONT;
            cstart_d = 1'b1;
            inc_d    = increment_i;
          end
          default: fsm_d = PG_IDLE;
        endcase
      end
    end
  end

  assign state_o        = fsm_to_osc_state(fsm_q);
  assign active_o       = active_q;
  assign sample_valid_o = valid_q;
  assign cycle_start_o  = cstart_q;

endmodule

// File: tb/tb_oscillator_phase_gen.sv
// Directed table-driven bench for oscillator_phase_gen at PHASE_WIDTH=8, FRAC_WIDTH=8.
module tb_oscillator_phase_gen;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        sample_tick_i = 1'b0;
  logic        note_on_i = 1'b0;
  logic        note_off_i = 1'b0;
  logic [15:0] increment_i = 16'h0000;
  OSCILLATOR::oscillator_state_t state_o;
  logic [7:0]  phase_o;
  logic        active_o;
  logic        sample_valid_o;
  logic        cycle_start_o;

  int checks = 0;
  int errors = 0;

  oscillator_phase_gen #(
    .PHASE_WIDTH (8),
    .FRAC_WIDTH  (8)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .sample_tick_i  (sample_tick_i),
    .note_on_i      (note_on_i),
    .note_off_i     (note_off_i),
    .increment_i    (increment_i),
    .state_o        (state_o),
    .phase_o        (phase_o),
    .active_o       (active_o),
    .sample_valid_o (sample_valid_o),
    .cycle_start_o  (cycle_start_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         on;
    bit         off;
    bit         tick;
    logic [15:0] inc;
    logic       st;
    logic [7:0] ph;
    logic       act;
    logic       vld;
    logic       cs;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] outs();
    return {1'(state_o), phase_o, active_o, sample_valid_o, cycle_start_o};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {st,ph,act,vld,cs}=%b_%h_%b%b%b expected %b_%h_%b%b%b",
               name, act[11], act[10:3], act[2], act[1], act[0],
               exp[11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input bit on, input bit off, input bit tick, input logic [15:0] inc,
                     input logic st, input logic [7:0] ph, input logic act,
                     input logic vld, input logic cs);
    vec_t v;
    v.on = on; v.off = off; v.tick = tick; v.inc = inc;
    v.st = st; v.ph = ph; v.act = act; v.vld = vld; v.cs = cs;
    vecs.push_back(v);
  endtask

  task automatic step(input bit on, input bit off, input bit tick, input logic [15:0] inc);
    @(negedge clk_i);
    note_on_i     = on;
    note_off_i    = off;
    sample_tick_i = tick;
    increment_i   = inc;
    @(posedge clk_i);
    #1;
    note_on_i     = 1'b0;
    note_off_i    = 1'b0;
    sample_tick_i = 1'b0;
  endtask

  initial begin
    // Idle behaviour straight out of reset.
    add(0,0,1,16'h4000, 0,8'h00,0,0,0);
    add(0,1,0,16'h4000, 0,8'h00,0,0,0);
    // Eight ticks at quarter-half-period steps: one full period.
    add(1,0,0,16'h4000, 0,8'h00,1,0,0);
    add(0,0,1,16'h4000, 0,8'h40,1,1,0);
    add(0,0,1,16'h4000, 0,8'h80,1,1,0);
    add(0,0,1,16'h4000, 0,8'hC0,1,1,0);
    add(0,0,1,16'h4000, 1,8'h00,1,1,0);
    add(0,0,1,16'h4000, 1,8'h40,1,1,0);
    add(0,0,1,16'h4000, 1,8'h80,1,1,0);
    add(0,0,1,16'h4000, 1,8'hC0,1,1,0);
    add(0,0,1,16'h4000, 0,8'h00,1,1,1);
    add(0,0,0,16'h4000, 0,8'h00,1,0,0);
    // Retune mid-period: new word applies only after the period boundary.
    add(1,0,0,16'h4000, 0,8'h00,1,0,0);
    add(0,0,1,16'h4000, 0,8'h40,1,1,0);
    add(0,0,1,16'h4000, 0,8'h80,1,1,0);
    add(0,0,1,16'h8000, 0,8'hC0,1,1,0);
    add(0,0,1,16'h8000, 1,8'h00,1,1,0);
    add(0,0,1,16'h8000, 1,8'h40,1,1,0);
    add(0,0,1,16'h8000, 1,8'h80,1,1,0);
    add(0,0,1,16'h8000, 1,8'hC0,1,1,0);
    add(0,0,1,16'h8000, 0,8'h00,1,1,1);
    add(0,0,1,16'h8000, 0,8'h80,1,1,0);
    add(0,0,1,16'h8000, 1,8'h00,1,1,0);
    add(0,0,1,16'h8000, 1,8'h80,1,1,0);
    // Simultaneous events restart the voice; note_off stops it.
    add(1,1,1,16'h1000, 0,8'h00,1,0,0);
    add(0,0,1,16'h1000, 0,8'h10,1,1,0);
    add(0,1,0,16'h1000, 0,8'h00,0,0,0);
    add(0,0,1,16'h1000, 0,8'h00,0,0,0);
    add(0,0,1,16'h1000, 0,8'h00,0,0,0);
    // Zero increment: valid pulses, no movement.
    add(1,0,0,16'h0000, 0,8'h00,1,0,0);
    for (int k = 0; k < 5; k++) add(0,0,1,16'h0000, 0,8'h00,1,1,0);
    // Maximum increment: one carry per tick, fraction retained.
    add(1,0,0,16'hFFFF, 0,8'h00,1,0,0);
    add(0,0,1,16'hFFFF, 0,8'hFF,1,1,0);
    add(0,0,1,16'hFFFF, 1,8'hFF,1,1,0);
    add(0,0,1,16'hFFFF, 0,8'hFF,1,1,1);
    add(0,0,1,16'hFFFF, 1,8'hFF,1,1,0);

    rst_n_i = 1'b0;
    #12;
    check("reset_state", outs(), {1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].on, vecs[i].off, vecs[i].tick, vecs[i].inc);
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].st, vecs[i].ph, vecs[i].act, vecs[i].vld, vecs[i].cs});
    end

    // sample_tick held high advances once per clock.
    step(1, 0, 0, 16'h4000);
    @(negedge clk_i);
    sample_tick_i = 1'b1;
    @(posedge clk_i); #1;
    check("held_tick1", outs(), {1'b0, 8'h40, 1'b1, 1'b1, 1'b0});
    @(posedge clk_i); #1;
    check("held_tick2", outs(), {1'b0, 8'h80, 1'b1, 1'b1, 1'b0});
    @(posedge clk_i); #1;
    check("held_tick3", outs(), {1'b0, 8'hC0, 1'b1, 1'b1, 1'b0});
    @(negedge clk_i);
    sample_tick_i = 1'b0;
    @(posedge clk_i); #1;
    check("held_release", outs(), {1'b0, 8'hC0, 1'b1, 1'b0, 1'b0});

    // Asynchronous reset while in BACK at phase 0x80.
    step(1, 0, 0, 16'h4000);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 16'h4000);
    check("pre_reset_back", outs(), {1'b1, 8'h80, 1'b1, 1'b1, 1'b0});
    #2;
    rst_n_i = 1'b0;
    #1;
    check("async_reset", outs(), {1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step(0, 0, 1, 16'h4000);
    check("post_reset_tick1", outs(), {1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    step(0, 0, 1, 16'h4000);
    check("post_reset_tick2", outs(), {1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    step(1, 0, 0, 16'h4000);
    step(0, 0, 1, 16'h4000);
    check("post_reset_restart", outs(), {1'b0, 8'h40, 1'b1, 1'b1, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oscillator_phase_gen.md
Name: oscillator_phase_gen

Overview:
Per-voice phase source that drives the waveform shapers (triangle, saw, square) with an `OSCILLATOR::oscillator_state_t` half-cycle flag and a `CONFIG::long_percent_t` phase.
- Runs a fixed-point phase accumulator advanced once per audio sample tick.
- Toggles FRONT/BACK on every accumulator wrap, so one full waveform period spans two wraps.
- Handles note-on/note-off gating.
- Applies a new tuning word only at note-on or at a period boundary, so frequency changes never glitch mid-cycle.

Parameters:
- PHASE_WIDTH, default `CONFIG::LONG_PERCENT_WIDTH`: width of the phase output, taken from the accumulator MSBs.
- FRAC_WIDTH, default 8: extra fractional accumulator bits below the phase output.
- ACC_WIDTH, default PHASE_WIDTH+FRAC_WIDTH: derived accumulator width. Not to be overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle pulse per audio sample.
- note_on  in  1  one-cycle pulse: start or restart the voice.
- note_off  in  1  one-cycle pulse: stop the voice.
- increment  in  ACC_WIDTH  tuning word added per tick (half-period = 2^ACC_WIDTH/increment ticks).
- state  out  `oscillator_state_t`  FRONT = rising half, BACK = falling half.
- phase  out  PHASE_WIDTH  accumulator[ACC_WIDTH-1 -: PHASE_WIDTH].
- active  out  1  high while the voice is running.
- sample_valid  out  1  one-cycle pulse: state/phase updated for this tick.
- cycle_start  out  1  one-cycle pulse coincident with sample_valid when BACK wraps to FRONT.

Behaviour:
Reset (async assert, sync deassert use): fsm=IDLE, acc=0, inc_latched=0. Outputs: state=FRONT, phase=0, active=0, sample_valid=0, cycle_start=0.

Internal FSM states: IDLE, FRONT, BACK. The `state` output shows FRONT in IDLE and FRONT; it shows BACK only in BACK.

Priority per cycle: note_on > note_off > sample_tick.
- note_on, any state:
  - acc←0, inc_latched←increment, fsm←FRONT, active←1, next cycle.
  - No sample_valid that cycle; a coincident tick is dropped.
- note_off, not IDLE: fsm←IDLE, acc←0, active←0 next cycle, no sample_valid.
- note_off in IDLE: ignored.
- sample_tick in FRONT/BACK:
  - {carry, acc_next} = acc + inc_latched, at ACC_WIDTH+1 bits.
  - acc←acc_next.
  - If carry: FRONT→BACK, or BACK→FRONT.
  - sample_valid=1 the following cycle; outputs are registered, latency 1 clk from tick.
- BACK→FRONT wrap:
  - cycle_start=1 with that sample_valid.
  - inc_latched←increment in the same cycle, so the new word applies from the next tick.
- sample_tick in IDLE: no update, no sample_valid.
- increment changes outside note_on / period boundary: ignored until the next boundary.

Edge cases:
- increment=0: phase holds, no wraps, sample_valid still pulses.
- Max increment (all ones): at most one carry per tick, so the state toggles at most once per tick.
- Residual fraction after a carry is kept, not zeroed; there is no phase drift.
- sample_tick held high for several cycles: advance once per cycle.
- phase/state are stable between sample_valid pulses.

Decomposition:
- `OSCILLATOR` package:
  - Add `phase_gen_fsm_t` (IDLE, FRONT, BACK) alongside the existing `oscillator_state_t`.
  - Add a function mapping fsm→`oscillator_state_t`.
- `CONFIG`: add `OSC_FRAC_WIDTH`, which becomes the FRAC_WIDTH default.
- One natural sub-module, `phase_accumulator`:
  - Registered acc with load-zero, add-enable and carry-out.
  - FSM and increment latching live in the parent.

Test Plan (PHASE_WIDTH=8, FRAC_WIDTH=8):
1. Reset mid-run: assert rst_n=0 asynchronously while in BACK with phase=0x80 → same cycle: state=FRONT, phase=0, active=0, no sample_valid until the next note_on.
2. note_on with increment=0x4000, then 8 ticks → (state, phase) sequence:
   - FRONT 0x40, FRONT 0x80, FRONT 0xC0, BACK 0x00, BACK 0x40, BACK 0x80, BACK 0xC0, FRONT 0x00.
   - cycle_start only on the 8th sample_valid.
3. increment=0x4000 running; change increment to 0x8000 after the 2nd tick:
   - Ticks 3–8 still step by 0x40.
   - After the 8th tick (cycle_start), steps are 0x80: FRONT 0x80, BACK 0x00.
4. Simultaneous events:
   - note_on+note_off+sample_tick in one cycle → voice restarts: active=1, phase=0, no sample_valid that cycle.
   - note_off alone → active=0 next cycle; further ticks produce no sample_valid.
5. Fractional wrap, increment=0xFFFF from acc=0:
   - Tick 1 → FRONT phase 0xFF.
   - Tick 2 → carry: BACK, acc=0xFFFE, phase 0xFF.
6. increment=0x0000 after note_on → 5 ticks give 5 sample_valid pulses, phase 0x00, state FRONT, no cycle_start.
